// File: rtl/vga_sprite_mixer_if.sv
// Collision event channel between the sprite mixer and the game logic.
//   coll_valid    : FIFO head holds an event (producer -> consumer)
//   coll_ready    : consumer accepts the head event (consumer -> producer)
//   coll_proj     : projectile index of the head event
//   coll_target   : invader index for laser hits, 0 for missile-on-player hits
//   coll_overflow : sticky until next frame, an event was dropped
interface vga_sprite_mixer_if #(
  parameter int N_PROJ    = 4,
  parameter int INV_IDX_W = 6
);
  localparam int PIDX_W = $clog2(N_PROJ);

  logic                 coll_valid;
  logic                 coll_ready;
  logic [PIDX_W-1:0]    coll_proj;
  logic [INV_IDX_W-1:0] coll_target;
  logic                 coll_overflow;

  modport master (
    output coll_valid, coll_proj, coll_target, coll_overflow,
    input  coll_ready
  );

  modport slave (
    input  coll_valid, coll_proj, coll_target, coll_overflow,
    output coll_ready
  );
endinterface

// File: rtl/vga_sprite_mixer.sv
// Pixel mixer and collision reporter for the invaders display path.
//   clk, rst        : clock, synchronous active-low reset
//   data_enable     : active video, aligned with pixel_x/pixel_y
//   frame           : 1-cycle pulse at start of blanking
//   pixel_x/pixel_y : current pixel coordinate
//   player_draw     : player sprite pixel, one cycle after pixel_x/y
//   invader_idx     : invader under the pixel (0 = none), one cycle after pixel_x/y
//   proj_active/x/y : per-projectile enable and position (index 0 = laser)
//   vga_out         : mixed colour, two cycles after pixel_x/y
//   coll            : collision event FIFO output (valid/ready)

// Per-projectile rectangle test. Upper bounds are formed one bit wider so a
// projectile near the right/bottom edge never wraps around to coordinate 0.
module vga_proj_hit #(
  parameter int COORD_W = 10,
  parameter int PROJ_W  = 2,
  parameter int PROJ_H  = 8
) (
  input  logic               active,
  input  logic               data_enable,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COORD_W-1:0] proj_x,
  input  logic [COORD_W-1:0] proj_y,
  output logic               hit
);
  logic [COORD_W:0] x_end, y_end;

  assign x_end = {1'b0, proj_x} + (COORD_W+1)'(PROJ_W);
  assign y_end = {1'b0, proj_y} + (COORD_W+1)'(PROJ_H);
  assign hit   = active & data_enable &
                 (pixel_x >= proj_x) & ({1'b0, pixel_x} < x_end) &
                 (pixel_y >= proj_y) & ({1'b0, pixel_y} < y_end);
endmodule

module vga_sprite_mixer #(
  parameter int         N_PROJ     = 4,
  parameter int         COORD_W    = 10,
  parameter int         INV_IDX_W  = 6,
  parameter int         PROJ_W     = 2,
  parameter int         PROJ_H     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PLAYER_COL = 8'h1C,
  parameter logic [7:0] PROJ_COL   = 8'hFF,
  parameter logic [7:0] INV_COL    = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_enable,
  input  logic                      frame,
  input  logic [COORD_W-1:0]        pixel_x,
  input  logic [COORD_W-1:0]        pixel_y,
  input  logic                      player_draw,
  input  logic [INV_IDX_W-1:0]      invader_idx,
  input  logic [N_PROJ-1:0]         proj_active,
  input  logic [N_PROJ*COORD_W-1:0] proj_x,
  input  logic [N_PROJ*COORD_W-1:0] proj_y,
  output logic [7:0]                vga_out,
  vga_sprite_mixer_if.master        coll
);
  localparam int PIDX_W = $clog2(N_PROJ);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [PIDX_W-1:0]    proj;
    logic [INV_IDX_W-1:0] target;
  } coll_evt_t;

  // ---------------- stage 1: projectile hit test ----------------
  logic [N_PROJ-1:0]   hit_d, hit_q;
  logic [STAGES-1:0]   vld_pipe;

  for (genvar i = 0; i < N_PROJ; i++) begin : g_lane
    vga_proj_hit #(
      .COORD_W(COORD_W), .PROJ_W(PROJ_W), .PROJ_H(PROJ_H)
    ) u_hit (
      .active      (proj_active[i]),
      .data_enable (data_enable),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .proj_x      (proj_x[i*COORD_W +: COORD_W]),
      .proj_y      (proj_y[i*COORD_W +: COORD_W]),
      .hit         (hit_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q    <= '0;
      vld_pipe <= '0;
    end else begin
      hit_q       <= hit_d;
      vld_pipe[0] <= data_enable;
    end
  end

  // ---------------- stage 2: colour mix and collision pick ----------------
  // player_draw/invader_idx arrive one cycle late, so they line up with hit_q.
  logic              inv_nz;
  logic [7:0]        pix_col;
  logic [N_PROJ-1:0] rep;       // projectile already reported this frame
  logic [N_PROJ-1:0] cand;
  logic [N_PROJ-1:0] cand_sel;  // one-hot, lowest candidate
  logic [PIDX_W-1:0] sel_idx;
  logic              cand_any;
  coll_evt_t         sel_evt;

  assign inv_nz = |invader_idx;

  always_comb begin
    pix_col = 8'h00;
    if (vld_pipe[0]) begin
      if (player_draw)  pix_col = PLAYER_COL;
      else if (|hit_q)  pix_col = PROJ_COL;
      else if (inv_nz)  pix_col = INV_COL;
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_PROJ; i++)
      cand[i] = hit_q[i] & ~rep[i] & ((i == 0) ? inv_nz : player_draw);
    cand_sel = cand & (~cand + N_PROJ'(1));
    sel_idx  = '0;
    for (int i = 0; i < N_PROJ; i++)
      if (cand_sel[i]) sel_idx = PIDX_W'(i);
  end

  assign cand_any       = |cand;
  assign sel_evt.proj   = sel_idx;
  assign sel_evt.target = cand_sel[0] ? invader_idx : '0;

  // ---------------- event FIFO ----------------
  // Pointers carry one extra wrap bit to tell full from empty.
  coll_evt_t   mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop, drop, ovf;
  coll_evt_t   head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & coll.coll_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push  = cand_any & (~full | pop);
  assign drop  = cand_any & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_out <= 8'h00;
      rep     <= '0;
      ovf     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
    end else begin
      vga_out <= pix_col;
      // Dropped events still mark the projectile as reported.
      if (frame) rep <= '0;
      else       rep <= rep | cand_sel;
      if (drop)       ovf <= 1'b1;
      else if (frame) ovf <= 1'b0;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= sel_evt;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign head               = mem[rd_ptr[AW-1:0]];
  assign coll.coll_valid    = ~empty;
  assign coll.coll_proj     = head.proj;
  assign coll.coll_target   = head.target;
  assign coll.coll_overflow = ovf;
endmodule

// File: tb/tb_vga_sprite_mixer.sv
module tb_vga_sprite_mixer;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int IW = 6;
  localparam int PW = 2;
  localparam int PH = 8;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, data_enable, frame, player_draw;
  logic [CW-1:0]   pixel_x, pixel_y;
  logic [IW-1:0]   invader_idx;
  logic [N-1:0]    proj_active;
  logic [N*CW-1:0] proj_x, proj_y;
  logic [7:0]      vga_out;

  vga_sprite_mixer_if #(.N_PROJ(N), .INV_IDX_W(IW)) coll ();

  vga_sprite_mixer #(
    .N_PROJ(N), .COORD_W(CW), .INV_IDX_W(IW), .PROJ_W(PW), .PROJ_H(PH), .FIFO_DEPTH(FD),
    .PLAYER_COL(8'h1C), .PROJ_COL(8'hFF), .INV_COL(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .data_enable(data_enable), .frame(frame),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .player_draw(player_draw),
    .invader_idx(invader_idx), .proj_active(proj_active),
    .proj_x(proj_x), .proj_y(proj_y), .vga_out(vga_out), .coll(coll)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Projectile geometry kept as plain ints; events as proj*256+target.
  bit   pact[N];
  int   ppx[N], ppy[N];
  bit   m_hit1[N];
  bit   m_de1;
  bit   m_rep[N];
  int   m_q[$];
  bit   m_ovf;
  logic [7:0] m_vga;
  bit   pend_pd;
  int   pend_inv;

  task automatic model_update();
    int  c;
    bit  any, pop, drop;
    if (!rst) begin
      m_vga = 8'h00; m_ovf = 0; m_de1 = 0; m_q.delete();
      for (int i = 0; i < N; i++) begin m_rep[i] = 0; m_hit1[i] = 0; end
      return;
    end
    pop = (m_q.size() > 0) && coll.coll_ready;
    c = -1; any = 0;
    for (int i = 0; i < N; i++) begin
      if (m_hit1[i]) any = 1;
      if (c < 0 && m_hit1[i] && !m_rep[i] &&
          ((i == 0) ? (invader_idx != 0) : (player_draw == 1'b1))) c = i;
    end
    if (!m_de1)                m_vga = 8'h00;
    else if (player_draw)      m_vga = 8'h1C;
    else if (any)              m_vga = 8'hFF;
    else if (invader_idx != 0) m_vga = 8'hFF;
    else                       m_vga = 8'h00;
    if (pop) void'(m_q.pop_front());
    drop = 0;
    if (c >= 0) begin
      m_rep[c] = 1;
      if (m_q.size() < FD) m_q.push_back(c * 256 + ((c == 0) ? int'(invader_idx) : 0));
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (frame) m_ovf = 0;
    if (frame) for (int i = 0; i < N; i++) m_rep[i] = 0;
    for (int i = 0; i < N; i++)
      m_hit1[i] = pact[i] && data_enable &&
                  int'(pixel_x) >= ppx[i] && int'(pixel_x) < ppx[i] + PW &&
                  int'(pixel_y) >= ppy[i] && int'(pixel_y) < ppy[i] + PH;
    m_de1 = data_enable;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("vga_out", vga_out, m_vga);
    chk("coll_valid", coll.coll_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("coll_proj", coll.coll_proj, m_q[0] / 256);
      chk("coll_target", coll.coll_target, m_q[0] % 256);
    end
    chk("coll_overflow", coll.coll_overflow, m_ovf);
  endtask

  task automatic set_proj(input int i, input bit act, input int x, input int y);
    pact[i] = act; ppx[i] = x; ppy[i] = y;
    proj_active[i] = act;
    proj_x[i*CW +: CW] = CW'(x);
    proj_y[i*CW +: CW] = CW'(y);
  endtask

  // Drives one pixel; sprite data for it is presented on the following cycle.
  task automatic pix(input int x, input int y, input bit de, input bit pd, input int inv, input bit fr = 0);
    pixel_x = CW'(x); pixel_y = CW'(y); data_enable = de; frame = fr;
    player_draw = pend_pd; invader_idx = IW'(pend_inv);
    pend_pd = pd; pend_inv = inv;
    step();
    frame = 0;
  endtask

  task automatic idle(input bit fr = 0);
    pix(0, 0, 0, 0, 0, fr);
  endtask

  task automatic pop_exp(input string tag, input int p, input int t);
    chk({tag, "_valid"}, coll.coll_valid, 1);
    chk({tag, "_proj"}, coll.coll_proj, p);
    chk({tag, "_target"}, coll.coll_target, t);
    coll.coll_ready = 1;
    idle();
    coll.coll_ready = 0;
  endtask

  task automatic rand_pix();
    int x, y;
    bit edge_sel;
    edge_sel = ($urandom_range(0, 9) == 0);
    if (edge_sel) begin
      x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(1020, 1023);
    end else begin
      x = $urandom_range(0, 47);
    end
    y = $urandom_range(0, 47);
    pix(x, y, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
        ($urandom_range(0, 1) == 1) ? $urandom_range(1, 63) : 0,
        $urandom_range(0, 32) == 0);
  endtask

  initial begin
    rst = 0; data_enable = 0; frame = 0; player_draw = 0;
    pixel_x = '0; pixel_y = '0; invader_idx = '0;
    proj_active = '0; proj_x = '0; proj_y = '0;
    coll.coll_ready = 0; pend_pd = 0; pend_inv = 0;
    for (int i = 0; i < N; i++) set_proj(i, 0, 0, 0);

    // Reset with random activity on the inputs
    for (int i = 0; i < N; i++) set_proj(i, 1, $urandom_range(0, 40), $urandom_range(0, 40));
    for (int k = 0; k < 3; k++) begin
      coll.coll_ready = 1'($urandom_range(0, 1));
      rand_pix();
    end
    chk("rst_vga", vga_out, 0);
    chk("rst_valid", coll.coll_valid, 0);
    chk("rst_ovf", coll.coll_overflow, 0);
    chk("rst_proj", coll.coll_proj, 0);
    chk("rst_target", coll.coll_target, 0);
    rst = 1; coll.coll_ready = 0;
    for (int i = 0; i < N; i++) set_proj(i, 0, 0, 0);
    idle(1); idle();
    coll.coll_ready = 1; idle(); idle(); coll.coll_ready = 0;

    // Latency and priority
    set_proj(0, 1, 100, 50);
    pix(100, 50, 1, 1, 0); idle();
    chk("lat_player", vga_out, 8'h1C);
    pix(100, 50, 1, 0, 0); idle();
    chk("lat_proj", vga_out, 8'hFF);
    pix(102, 50, 1, 0, 0); idle();
    chk("lat_xend", vga_out, 8'h00);

    // Laser over invader 7: one event per frame
    for (int rpt = 0; rpt < 2; rpt++) begin
      for (int y = 50; y < 58; y++)
        for (int x = 100; x < 102; x++) pix(x, y, 1, 0, 7);
      idle(); idle();
      pop_exp("laser", 0, 7);
      chk("laser_once", coll.coll_valid, 0);
      idle(1);
    end

    // Two missiles over the player at once
    set_proj(0, 0, 0, 0);
    set_proj(1, 1, 200, 100);
    set_proj(3, 1, 200, 100);
    pix(200, 100, 1, 1, 0); pix(201, 100, 1, 1, 0); pix(202, 100, 1, 0, 0);
    idle(); idle();
    pop_exp("sim_a", 1, 0);
    pop_exp("sim_b", 3, 0);
    chk("sim_total", coll.coll_valid, 0);
    idle(1);

    // Overflow: four queued events, fifth dropped after a frame
    set_proj(0, 1, 10, 10); set_proj(1, 1, 20, 10);
    set_proj(2, 1, 30, 10); set_proj(3, 1, 40, 10);
    pix(10, 10, 1, 0, 3); pix(20, 10, 1, 1, 0);
    pix(30, 10, 1, 1, 0); pix(40, 10, 1, 1, 0);
    idle(); idle();
    chk("ovf_pre", coll.coll_overflow, 0);
    idle(1);
    pix(10, 10, 1, 0, 9); idle(); idle();
    chk("ovf_set", coll.coll_overflow, 1);
    idle(); idle();
    chk("ovf_hold", coll.coll_overflow, 1);
    idle(1);
    chk("ovf_clr", coll.coll_overflow, 0);
    pop_exp("ord0", 0, 3);
    pop_exp("ord1", 1, 0);
    pop_exp("ord2", 2, 0);
    pop_exp("ord3", 3, 0);
    chk("ord_empty", coll.coll_valid, 0);
    idle(1);

    // Right edge: no wrap onto x=0..1, and data_enable gating
    for (int i = 1; i < N; i++) set_proj(i, 0, 0, 0);
    set_proj(0, 1, 1022, 10);
    pix(0, 10, 1, 0, 0); pix(1, 10, 1, 0, 0);
    chk("edge_x0", vga_out, 8'h00);
    idle();
    chk("edge_x1", vga_out, 8'h00);
    pix(1022, 10, 1, 0, 0); pix(1023, 10, 1, 0, 0);
    chk("edge_1022", vga_out, 8'hFF);
    idle();
    chk("edge_1023", vga_out, 8'hFF);
    pix(1022, 10, 0, 0, 5); pix(1023, 10, 0, 0, 5); idle();
    chk("de_vga", vga_out, 8'h00);
    idle();
    chk("de_noevt", coll.coll_valid, 0);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 7) == 0)
            set_proj(i, 1, $urandom_range(1019, 1023), $urandom_range(0, 40));
          else
            set_proj(i, $urandom_range(0, 3) != 0, $urandom_range(0, 40), $urandom_range(0, 40));
      coll.coll_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) != 0);
      rand_pix();
    end
    rst = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
